// File: rtl/adder_accum_pkg.sv
// rtl/adder_accum_pkg.sv - shared constants and state encoding for adder_accum_25bit
package adder_accum_pkg;

  localparam int ACC_WIDTH = 25;
  localparam int ACC_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/csa_25bit.sv
// rtl/csa_25bit.sv - carry-select adder, low half ripples, high half precomputed for both carries
module csa_25bit #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic [LO_W:0] lo;
  logic [HI_W:0] hi0;
  logic [HI_W:0] hi1;

  always_comb begin
    lo  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, cin};
    hi0 = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]};
    hi1 = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};
    // the low half's carry only steers a mux, keeping the critical path short
    sum  = {(lo[LO_W] ? hi1[HI_W-1:0] : hi0[HI_W-1:0]), lo[LO_W-1:0]};
    cout = lo[LO_W] ? hi1[HI_W] : hi0[HI_W];
  end

endmodule

// File: rtl/adder_accum_25bit.sv
// rtl/adder_accum_25bit.sv - streaming group accumulator around csa_25bit
// ADDER_ACCUM_SAT_EN selects a saturating sum instead of wrap-and-count-carries.
module adder_accum_25bit
  import adder_accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = ACC_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic [CNT_W-1:0] o_carries,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] carries_q, carries_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic [CNT_W-1:0] res_carries_q, res_carries_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             beat;

  csa_25bit #(.WIDTH(WIDTH)) u_csa (
    .a    (acc_q),
    .b    (i_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign o_ready   = (state_q != HOLD) && !i_rst;
  assign o_valid   = (state_q == HOLD) && !i_rst;
  assign o_sum     = i_rst ? '0 : res_sum_q;
  assign o_carries = i_rst ? '0 : res_carries_q;
  assign o_count   = i_rst ? '0 : res_count_q;
  assign o_ovf     = i_rst ? 1'b0 : res_ovf_q;

  assign beat = i_valid && o_ready;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    carries_d     = carries_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    res_sum_d     = res_sum_q;
    res_carries_d = res_carries_q;
    res_count_d   = res_count_q;
    res_ovf_d     = res_ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
`ifdef ADDER_ACCUM_SAT_EN
          // once saturated, any further nonzero operand carries again, so acc stays pinned
          if (add_cout) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end
`else
          if (add_cout) begin
            if (carries_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              carries_d = carries_q + 1'b1;
            end
          end
`endif
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end

          if (i_last) begin
            state_d       = HOLD;
            res_sum_d     = acc_d;
            res_carries_d = carries_d;
            res_count_d   = count_d;
            res_ovf_d     = ovf_d;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      HOLD: begin
        if (i_ready) begin
          state_d   = IDLE;
          acc_d     = '0;
          carries_d = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        acc_d     = '0;
        carries_d = '0;
        count_d   = '0;
        ovf_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      carries_q     <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      res_sum_q     <= '0;
      res_carries_q <= '0;
      res_count_q   <= '0;
      res_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      carries_q     <= carries_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      res_sum_q     <= res_sum_d;
      res_carries_q <= res_carries_d;
      res_count_q   <= res_count_d;
      res_ovf_q     <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_accum_25bit.sv
// tb/tb_adder_accum_25bit.sv - scoreboard bench for adder_accum_25bit
module tb_adder_accum_25bit;

  localparam int W = 25;

  typedef struct {
    logic [W-1:0] sum;
    int           carries;
    int           count;
    bit           ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
  logic [W-1:0] i_data = '0;
  logic         o_ready, o_valid, o_ovf;
  logic [W-1:0] o_sum;
  logic [7:0]   o_carries, o_count;

  logic         v2 = 1'b0, l2 = 1'b0;
  logic [W-1:0] d2 = '0;
  logic         o_ready2, o_valid2, o_ovf2;
  logic [W-1:0] o_sum2;
  logic [1:0]   o_carries2, o_count2;

  adder_accum_25bit dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_carries(o_carries), .o_count(o_count), .o_ovf(o_ovf)
  );

  adder_accum_25bit #(.WIDTH(W), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(o_ready2),
    .i_data(d2), .i_last(l2), .o_valid(o_valid2), .i_ready(1'b1),
    .o_sum(o_sum2), .o_carries(o_carries2), .o_count(o_count2), .o_ovf(o_ovf2)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer addition with an explicit 2^W wrap test per operand.
  function automatic exp_t model(input logic [W-1:0] beats[$], input int cmax);
    exp_t   e;
    longint acc = 0;
    longint lim = longint'(1) << W;
    int     nc = 0;
    bit     ovf = 1'b0;
    foreach (beats[i]) begin
      acc += longint'(beats[i]);
      if (acc >= lim) begin
        acc -= lim;
`ifdef ADDER_ACCUM_SAT_EN
        acc = lim - 1;
        ovf = 1'b1;
`else
        nc++;
`endif
      end
    end
    e.count = beats.size();
    if (nc > cmax) begin nc = cmax; ovf = 1'b1; end
    if (e.count > cmax) begin e.count = cmax; ovf = 1'b1; end
    e.sum     = acc[W-1:0];
    e.carries = nc;
    e.ovf     = ovf;
    e.cyc     = 0;
    return e;
  endfunction

  bit           holding = 1'b0;
  logic [W-1:0] h_sum;
  logic [7:0]   h_car, h_cnt;
  logic         h_ovf;

  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else if (o_valid) begin
      chk("ready_low_in_hold", longint'(o_ready), 0);
      if (!holding) begin
        if (q.size() == 0) begin
          chk("unexpected_result_count", 1, 0);
        end else begin
          chk("sum", longint'(o_sum), longint'(q[0].sum));
          chk("carries", longint'(o_carries), longint'(q[0].carries));
          chk("count", longint'(o_count), longint'(q[0].count));
          chk("ovf", longint'(o_ovf), longint'(q[0].ovf));
          chk("latency_cycle", longint'(cyc), longint'(q[0].cyc));
        end
        holding = 1'b1;
        h_sum = o_sum; h_car = o_carries; h_cnt = o_count; h_ovf = o_ovf;
      end else begin
        chk("hold_stable", longint'({o_sum, o_carries, o_count, o_ovf}),
            longint'({h_sum, h_car, h_cnt, h_ovf}));
      end
      if (i_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        holding = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic last, output bit ok);
    bit acc;
    ok = 1'b0;
    i_valid = 1'b1; i_data = d; i_last = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) begin ok = 1'b1; break; end
    end
    i_valid = 1'b0;
    i_data  = W'($urandom);
    i_last  = 1'($urandom_range(0, 1));
    if (!ok) chk("beat_accept_timeout", 1, 0);
  endtask

  task automatic send_group(input logic [W-1:0] beats[$], input int gap);
    bit   ok;
    exp_t e;
    int   g;
    for (int i = 0; i < beats.size(); i++) begin
      if (i > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin @(posedge clk); #1; end
      end
      send_beat(beats[i], (i == beats.size() - 1), ok);
    end
    e = model(beats, 255);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("scoreboard_drained", longint'(q.size()), 0);
  endtask

  initial begin
    logic [W-1:0] g[$];
    logic [W-1:0] d;
    bit ok;
    exp_t e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", longint'(o_ready), 0);
    chk("reset_valid", longint'(o_valid), 0);
    chk("reset_outputs", longint'({o_sum, o_carries, o_count, o_ovf}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", longint'(o_ready), 1);

    g = '{25'h0000123};
    send_group(g, 0);
    drain();

    g = '{25'h1FFFFFF, 25'h0000001, 25'h0000005};
    send_group(g, 0);
    drain();

    g = '{25'h1000000, 25'h0ABCDEF, 25'h0F00001};
    send_group(g, 0);
    send_group(g, 1);
    send_group(g, 3);
    drain();

    i_ready = 1'b0;
    g = '{25'h100, 25'h200};
    send_group(g, 0);
    i_valid = 1'b1; i_data = 25'h777; i_last = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_valid_held", longint'(o_valid), 1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_dropped", longint'(o_valid), 0);
    chk("bp_ready_back", longint'(o_ready), 1);
    drain();

    send_beat(25'h10, 1'b0, ok);
    send_beat(25'h20, 1'b0, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    g = '{25'h5};
    send_group(g, 0);
    drain();

    for (int i = 0; i < 5; i++) begin
      v2 = 1'b1; d2 = 25'h1FFFFFF; l2 = (i == 4);
      @(posedge clk); #1;
    end
    v2 = 1'b0;
    g = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};
    e = model(g, 3);
    chk("sat2_valid", longint'(o_valid2), 1);
    chk("sat2_sum", longint'(o_sum2), longint'(e.sum));
    chk("sat2_carries", longint'(o_carries2), longint'(e.carries));
    chk("sat2_count", longint'(o_count2), longint'(e.count));
    chk("sat2_ovf", longint'(o_ovf2), longint'(e.ovf));
    @(posedge clk); #1;
    chk("sat2_valid_drop", longint'(o_valid2), 0);

    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      g.delete();
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        d = ($urandom_range(0, 2) == 0) ? W'(25'h1FFFFFF - W'($urandom_range(0, 255)))
                                        : W'($urandom);
        g.push_back(d);
      end
      send_group(g, -1);
    end
    g.delete();
    for (int j = 0; j < 300; j++) g.push_back(25'h1);
    send_group(g, 0);
    rand_rdy = 1'b0;
    #2;
    i_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_accum_25bit.md
# adder_accum_25bit

Streaming group accumulator that sits directly upstream of the 25-bit carry-select adder. It feeds the adder its running total and each new operand, registers the adder's sum and carry-out every cycle, and presents one total per operand group. Operands arrive on a valid/ready stream with a last-of-group flag. The result leaves on a second valid/ready stream with carry and term counts.

## Interface
- WIDTH, 25, operand/sum width; must match the adder instance
- CNT_W, 8, width of the carry counter and the term counter
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  operand beat valid
- o_ready  out  1  block accepts an operand beat
- i_data  in  WIDTH  operand
- i_last  in  1  beat is last of its group
- o_valid  out  1  group result valid
- i_ready  in  1  consumer accepts result
- o_sum  out  WIDTH  group total modulo 2^WIDTH (saturated when the saturation macro is defined)
- o_carries  out  CNT_W  count of adder carry-outs in the group
- o_count  out  CNT_W  beats in the group
- o_ovf  out  1  a counter saturated, or the sum saturated, during the group

## Operation
- Beat accepted when i_valid && o_ready.
- o_ready = (state != HOLD) && !i_rst.
- States:
  - IDLE: acc=0, counters 0.
  - ACCUM: at least one beat taken, last not yet seen.
  - HOLD: result held.
- Transitions:
  - IDLE to ACCUM: beat && !i_last.
  - IDLE or ACCUM to HOLD: beat && i_last.
  - HOLD to IDLE: i_ready.
  - No other transitions.
- Each beat:
  - {cout, nsum} = acc + i_data via the adder, cin=0.
  - acc <= nsum.
  - o_carries/carry counter += cout.
  - Term counter += 1.
- Counters saturate at 2^CNT_W-1. An increment attempted at saturation sets sticky ovf.
- On the last beat, the post-add acc, counters and ovf are copied to o_sum/o_carries/o_count/o_ovf. o_valid is then set.
- Leaving HOLD clears acc, both counters and ovf. Outputs stay at their last values and are qualified only by o_valid.
- i_valid gaps inside a group are allowed and do not affect the result.
- i_data/i_last are ignored when no beat is accepted.

## Timing
- Reset, synchronous: state=IDLE, acc=0, counters 0. All outputs are 0 while i_rst is high, including o_ready.
  - o_ready=1 in the first cycle after i_rst falls.
- Reset mid-group or in HOLD discards all partial or pending data; no result is emitted.
- Beats are accepted back-to-back at 1 per cycle. The single adder path, acc plus i_data, must close in one cycle.
- Latency: last beat accepted at edge N gives o_valid=1 from cycle N+1.
- o_valid is held with o_sum/o_carries/o_count/o_ovf stable until i_ready. If i_ready is already high, o_valid lasts exactly one cycle.
- No beat is accepted in HOLD, so a new group's first beat is accepted no earlier than the cycle after the result handshake.
- Minimum spacing between results: group length + 1 cycles.

## Configuration
- ADDER_ACCUM_SAT_EN defined:
  - Any cout forces acc to 2^WIDTH-1 and sets ovf.
  - Acc stays all-ones for the rest of the group.
  - The carry counter is not incremented, so o_carries is always 0.
- ADDER_ACCUM_SAT_EN undefined: sum wraps modulo 2^WIDTH, carries are counted, and ovf reflects counter saturation only.
- The term counter behaves the same in both builds.

## Structure
- Package adder_accum_pkg holds the 2-bit state encoding (IDLE=0, ACCUM=1, HOLD=2) and the default WIDTH/CNT_W constants.
- One sub-module: the existing csa_25bit instance as the adder datapath. Control, counters and output registers are local.

## Test plan
- Single beat 0x0000123 with i_last -> next cycle o_valid=1, o_sum=0x0000123, o_count=1, o_carries=0, o_ovf=0.
- Beats 0x1FFFFFF, 0x0000001, 0x0000005 (last):
  - Macro undefined -> o_sum=0x0000005, o_carries=1, o_count=3.
  - Macro defined -> o_sum=0x1FFFFFF, o_carries=0, o_ovf=1.
- Backpressure: i_ready=0 for 4 cycles after o_valid -> outputs stable, o_ready=0, offered beats not taken. Then i_ready=1 -> next cycle o_valid=0, o_ready=1.
- Reset mid-group: beats 0x10, 0x20, then i_rst for one cycle, then 0x5 (last) -> o_sum=0x5, o_count=1, no earlier result emitted.
- CNT_W=2, five beats of 0x1FFFFFF, last on the fifth, macro undefined -> o_sum=0x1FFFFFB, o_carries=3, o_count=3, o_ovf=1.
- Same three-beat group sent with i_valid gaps of 0, 1 and 3 cycles -> identical results; o_valid rises one cycle after the last beat in each case.
